// File: rtl/dht11_read_scheduler_if.sv
// Bundles the user-side request/status and receiver-side handshake of the DHT11 read scheduler.
// The scheduler is the slave; the user logic and the start/receiver pair together act as master.
interface dht11_read_scheduler_if;
    logic        trigger;
    logic        auto_en;
    logic        start_o;
    logic        rx_done;
    logic [39:0] rx_frame;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        data_valid;
    logic        busy;
    logic        err_sum;
    logic        err_tmo;

    modport slave (
        input  trigger, auto_en, rx_done, rx_frame,
        output start_o, humidity, temperature, data_valid, busy, err_sum, err_tmo
    );

    modport master (
        output trigger, auto_en, rx_done, rx_frame,
        input  start_o, humidity, temperature, data_valid, busy, err_sum, err_tmo
    );
endinterface

// File: rtl/dht11_read_scheduler.sv
// DHT11 read sequencer: fires the start pulse, enforces the sensor holdoff, supervises the
// receiver with a timeout, validates the checksum, retries and latches good readings.
module dht11_read_scheduler #(
    parameter int MIN_GAP     = 2_000_000,
    parameter int TIMEOUT     = 30_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dht11_read_scheduler_if.slave bus
);
    localparam int HW = $clog2(MIN_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] GAP_LD    = HW'(MIN_GAP - 1);
    localparam logic [TW-1:0] TMO_LD    = TW'(TIMEOUT - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_HOLDOFF
    } state_t;

    typedef struct packed {
        logic [7:0] hum_i;
        logic [7:0] hum_d;
        logic [7:0] tmp_i;
        logic [7:0] tmp_d;
        logic [7:0] sum;
    } frame_t;

    state_t        state;
    frame_t        frame_q;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    retry_cnt;
    logic [3:0]    retry_inc;
    logic          retry_flag;
    logic          pend;
    logic          sum_ok;
    logic          fail_tmo;
    logic          fail_sum;

    logic          start_q;
    logic          dv_q;
    logic          busy_q;
    logic          err_sum_q;
    logic          err_tmo_q;
    logic [15:0]   hum_q;
    logic [15:0]   tmp_q;

    function automatic logic [7:0] frame_sum(input frame_t f);
        return 8'(f.hum_i + f.hum_d + f.tmp_i + f.tmp_d);
    endfunction

    always_comb begin
        sum_ok    = (frame_q.sum == frame_sum(frame_q));
        retry_inc = retry_cnt + 4'd1;
        // rx_done takes priority over an expiring timeout in the same cycle
        fail_tmo  = (state == S_WAIT) && !bus.rx_done && (tmo_cnt == '0);
        fail_sum  = (state == S_CHECK) && !sum_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_HOLDOFF;
            hold_cnt   <= GAP_LD;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            retry_flag <= 1'b0;
            pend       <= 1'b0;
            frame_q    <= '0;
            start_q    <= 1'b0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_sum_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            hum_q      <= '0;
            tmp_q      <= '0;
        end else begin
            start_q <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b1;

            // one-deep request memory; further triggers while busy are dropped
            if (bus.trigger && state != S_IDLE)
                pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.trigger || pend || bus.auto_en) begin
                        state <= S_START;
                        pend  <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                S_START: begin
                    start_q <= 1'b1;
                    tmo_cnt <= TMO_LD;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.rx_done) begin
                        frame_q <= bus.rx_frame;
                        state   <= S_CHECK;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end

                S_CHECK: begin
                    if (sum_ok) begin
                        hum_q     <= {frame_q.hum_i, frame_q.hum_d};
                        tmp_q     <= {frame_q.tmp_i, frame_q.tmp_d};
                        dv_q      <= 1'b1;
                        retry_cnt <= '0;
                        err_sum_q <= 1'b0;
                        err_tmo_q <= 1'b0;
                        hold_cnt  <= GAP_LD;
                        state     <= S_HOLDOFF;
                    end
                end

                S_HOLDOFF: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (retry_flag) begin
                        retry_flag <= 1'b0;
                        state      <= S_START;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase

            // shared failure path for timeout and checksum errors
            if (fail_tmo || fail_sum) begin
                state    <= S_HOLDOFF;
                hold_cnt <= GAP_LD;
                if (retry_inc < RETRY_LIM) begin
                    retry_cnt  <= retry_inc;
                    retry_flag <= 1'b1;
                end else begin
                    retry_cnt  <= '0;
                    retry_flag <= 1'b0;
                    err_tmo_q  <= err_tmo_q | fail_tmo;
                    err_sum_q  <= err_sum_q | fail_sum;
                end
            end
        end
    end

    assign bus.start_o     = start_q;
    assign bus.data_valid  = dv_q;
    assign bus.busy        = busy_q;
    assign bus.err_sum     = err_sum_q;
    assign bus.err_tmo     = err_tmo_q;
    assign bus.humidity    = hum_q;
    assign bus.temperature = tmp_q;
endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed + randomized bench for dht11_read_scheduler against a transaction-level model
// of attempt outcomes, retry chains, holdoff spacing and sticky error flags.
module tb_dht11_read_scheduler;
    localparam int MIN_GAP     = 20;
    localparam int TIMEOUT     = 50;
    localparam int MAX_RETRIES = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dht11_read_scheduler_if bus ();

    dht11_read_scheduler #(
        .MIN_GAP    (MIN_GAP),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_start = 0;
    int exp_gap    = 0;

    // reference model state
    logic [15:0] m_hum  = '0;
    logic [15:0] m_tmp  = '0;
    logic        m_esum = 1'b0;
    logic        m_etmo = 1'b0;
    int          streak = 0;
    bit          m_retry = 0;
    bit          m_pend  = 0;
    bit          m_auto  = 0;
    bit          m_next  = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [39:0] mk_frame(input bit good);
        int a, b, c, e, s;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        c = $urandom_range(0, 255);
        e = $urandom_range(0, 255);
        s = (a + b + c + e) % 256;
        if (!good) s = (s + $urandom_range(1, 255)) % 256;
        return {a[7:0], b[7:0], c[7:0], e[7:0], s[7:0]};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {bus.start_o, bus.busy, bus.data_valid, bus.err_sum, bus.err_tmo}, 0);
        check({tag, "_hum"}, bus.humidity, 0);
        check({tag, "_tmp"}, bus.temperature, 0);
    endtask

    // waits for the next start_o; stray rx_done pulses land outside WAIT and must be ignored
    task automatic expect_start(input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < exp_gap + 4 * MIN_GAP + TIMEOUT) begin
            tick();
            n++;
            bus.rx_done = 1'b0;
            if (bus.start_o) seen = 1;
            else if ($urandom_range(0, 7) == 0) begin
                bus.rx_done  = 1'b1;
                bus.rx_frame = mk_frame(1);
            end
        end
        bus.rx_done = 1'b0;
        check({tag, "_seen"}, seen, 1);
        check({tag, "_gap"}, cyc - last_start, exp_gap);
        check({tag, "_busy"}, bus.busy, 1);
        last_start = cyc;
    endtask

    task automatic expect_quiet(input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3 * MIN_GAP; i++) begin
            tick();
            bus.rx_done = 1'b0;
            if (bus.start_o) pulses++;
            if ($urandom_range(0, 5) == 0) begin
                bus.rx_done  = 1'b1;
                bus.rx_frame = mk_frame(1);
            end
        end
        bus.rx_done = 1'b0;
        tick();
        check({tag, "_nostart"}, pulses, 0);
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_hum"}, bus.humidity, m_hum);
        check({tag, "_tmp"}, bus.temperature, m_tmp);
    endtask

    task automatic trig_and_expect(input string tag);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        tick();
        check({tag, "_lat"}, bus.start_o, 1);
        last_start = cyc;
    endtask

    // Called right after start_o is seen. kind 0 = reply after d cycles, 1 = no reply.
    task automatic do_attempt(input int kind, input int d, input logic [39:0] f,
                              input int ntrig, input string tag);
        bit ok;
        int endo;
        int s;
        if (kind == 0 && d < TIMEOUT) begin
            for (int i = 0; i < d; i++) begin
                bus.trigger = (i < ntrig);
                if (i < ntrig) m_pend = 1;
                tick();
            end
            bus.trigger  = 1'b0;
            bus.rx_done  = 1'b1;
            bus.rx_frame = f;
            tick();
            bus.rx_done = 1'b0;
            tick();
            s    = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
            ok   = ((s % 256) == int'(f[7:0]));
            endo = d + 2;
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                bus.trigger = (i < ntrig);
                if (i < ntrig) m_pend = 1;
                tick();
            end
            bus.trigger = 1'b0;
            ok   = 0;
            endo = TIMEOUT;
        end

        if (ok) begin
            m_hum   = f[39:24];
            m_tmp   = f[23:8];
            m_esum  = 1'b0;
            m_etmo  = 1'b0;
            streak  = 0;
            m_retry = 0;
        end else begin
            streak++;
            if (streak < MAX_RETRIES) begin
                m_retry = 1;
            end else begin
                m_retry = 0;
                streak  = 0;
                if (kind == 0 && d < TIMEOUT) m_esum = 1'b1;
                else                          m_etmo = 1'b1;
            end
        end

        check({tag, "_dv"}, bus.data_valid, ok);
        check({tag, "_hum"}, bus.humidity, m_hum);
        check({tag, "_tmp"}, bus.temperature, m_tmp);
        check({tag, "_esum"}, bus.err_sum, m_esum);
        check({tag, "_etmo"}, bus.err_tmo, m_etmo);

        if (kind == 0 && d >= TIMEOUT) begin
            for (int i = TIMEOUT; i < d; i++) tick();
            bus.rx_done  = 1'b1;
            bus.rx_frame = f;
            tick();
            bus.rx_done = 1'b0;
        end
        tick();
        check({tag, "_dv_drop"}, bus.data_valid, 0);

        // holdoff spans MIN_GAP cycles; a retry goes straight to START, anything else via IDLE
        exp_gap = endo + MIN_GAP + (m_retry ? 1 : 2);
        m_next  = m_retry || m_auto || m_pend;
        if (!m_retry && m_next) m_pend = 0;
    endtask

    initial begin
        int kind;
        int d;
        bus.trigger  = 1'b0;
        bus.auto_en  = 1'b0;
        bus.rx_done  = 1'b0;
        bus.rx_frame = '0;

        repeat (3) tick();
        check_zero("reset");

        // trigger right after release waits out the power-up holdoff
        rst = 1'b1;
        last_start = cyc;
        exp_gap = MIN_GAP + 2;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        check("busy_after_rst", bus.busy, 1);
        expect_start("first");

        do_attempt(0, $urandom_range(2, TIMEOUT - 1), 40'h37_00_19_00_50, 1, "good1");
        check("good1_hum_val", m_hum, 16'h3700);

        for (int k = 0; k < 3; k++) begin
            expect_start("bad_start");
            do_attempt(0, $urandom_range(0, TIMEOUT - 1), 40'h37_00_19_00_51, 0, "bad");
        end
        check("bad_err_sum", bus.err_sum, 1);
        expect_quiet("after_bad");

        trig_and_expect("tmo0");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) expect_start("tmo_start");
            do_attempt(1, 0, '0, 0, "tmo");
        end
        expect_quiet("after_tmo");

        // reply on the last WAIT cycle still counts and clears both sticky flags
        trig_and_expect("edge");
        do_attempt(0, TIMEOUT - 1, mk_frame(1), 0, "edge_ok");
        expect_quiet("after_edge");

        // reply one cycle too late is a timeout followed by a retry
        trig_and_expect("late");
        do_attempt(0, TIMEOUT, mk_frame(1), 0, "late");
        expect_start("late_retry");
        bus.auto_en = 1'b1;
        m_auto = 1;
        do_attempt(0, $urandom_range(0, TIMEOUT - 1), mk_frame(1), 0, "auto_on");

        for (int k = 0; k < 16; k++) begin
            expect_start("rnd_start");
            kind = $urandom_range(0, 4);
            d = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT - 1);
            case (kind)
                0, 1:    do_attempt(0, d, mk_frame(1), $urandom_range(0, 2), "rnd_good");
                2:       do_attempt(0, d, mk_frame(0), $urandom_range(0, 2), "rnd_bad");
                3:       do_attempt(1, 0, '0, $urandom_range(0, 2), "rnd_tmo");
                default: do_attempt(0, TIMEOUT, mk_frame(1), 0, "rnd_late");
            endcase
        end

        // asynchronous reset in the middle of WAIT
        expect_start("pre_rst");
        repeat (3) tick();
        #3 rst = 1'b0;
        #1 check_zero("rst_wait");
        tick();
        tick();
        rst = 1'b1;
        m_hum = '0; m_tmp = '0; m_esum = 0; m_etmo = 0;
        streak = 0; m_retry = 0; m_pend = 0;
        last_start = cyc;
        exp_gap = MIN_GAP + 2;
        expect_start("post_rst");
        bus.auto_en = 1'b0;
        m_auto = 0;
        do_attempt(0, $urandom_range(0, TIMEOUT - 1), mk_frame(1), 0, "post_rst");
        expect_quiet("post_rst_q");

        // a burst of triggers while busy yields exactly one extra read
        trig_and_expect("xtrig");
        do_attempt(0, 10, mk_frame(1), 3, "xtrig");
        expect_start("xtrig_extra");
        do_attempt(0, $urandom_range(0, TIMEOUT - 1), mk_frame(1), 0, "xtrig2");
        expect_quiet("xtrig_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
